// File: rtl/tex_texel_unpack_pkg.sv
// Shared texture-pipeline definitions.
// Holds the texture format codes, the colour-packet and texel widths used by
// the fetcher, the address calculator and this unpacker, plus the small bit
// replication helpers that widen 5/6-bit colour channels to 8 bits.
package tex_texel_unpack_pkg;

  localparam int TEX_PKT_W   = 128;  // one memory line from the fetcher
  localparam int TEX_TEXEL_W = 32;   // RGBA8888 texel
  localparam int TEX_XLSB_W  = 4;    // texel index bits within a line

  localparam logic [1:0] TEX_FMT_RGBA8888 = 2'd0;
  localparam logic [1:0] TEX_FMT_RGB565   = 2'd1;
  localparam logic [1:0] TEX_FMT_L8       = 2'd2;
  localparam logic [1:0] TEX_FMT_A8       = 2'd3;

  // Widen a 5-bit channel by replicating its top bits into the new LSBs,
  // so 5'h00 maps to 8'h00 and 5'h1F maps to 8'hFF.
  function automatic logic [7:0] tex_rep5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  // Same idea for the 6-bit green channel of RGB565.
  function automatic logic [7:0] tex_rep6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/tex_texel_unpack_if.sv
// Packet-in / texel-out bus of the texel unpacker.
// Groups both valid/ready channels:
//   pkt_valid/pkt_ready + color_pkt, x_lsb, tex_fmt   (fetcher -> unpacker)
//   texel_valid/texel_ready + texel_rgba              (unpacker -> shader)
// slave  : the unpacker's view (consumes packets, produces texels).
// master : the surrounding pipeline's view (produces packets, consumes texels).
interface tex_texel_unpack_if;
  import tex_texel_unpack_pkg::*;

  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [TEX_PKT_W-1:0]   color_pkt;
  logic [TEX_XLSB_W-1:0]  x_lsb;
  logic [1:0]             tex_fmt;
  logic                   texel_valid;
  logic                   texel_ready;
  logic [TEX_TEXEL_W-1:0] texel_rgba;

  modport master (
    output pkt_valid, color_pkt, x_lsb, tex_fmt, texel_ready,
    input  pkt_ready, texel_valid, texel_rgba
  );

  modport slave (
    input  pkt_valid, color_pkt, x_lsb, tex_fmt, texel_ready,
    output pkt_ready, texel_valid, texel_rgba
  );

endinterface

// File: rtl/tex_texel_unpack_fmt_expand.sv
// tex_fmt_expand: purely combinational texel format expansion to RGBA8888.
// Ports:
//   lane  in  32  raw texel, right-aligned (16-bit and 8-bit formats use the LSBs)
//   fmt   in  2   texture format code
//   rgba  out 32  R[31:24] G[23:16] B[15:8] A[7:0]
module tex_fmt_expand
  import tex_texel_unpack_pkg::*;
(
  input  logic [TEX_TEXEL_W-1:0] lane,
  input  logic [1:0]             fmt,
  output logic [TEX_TEXEL_W-1:0] rgba
);

  // Per-format channel expansion
  always_comb begin
    rgba = lane;
    case (fmt)
      TEX_FMT_RGBA8888: rgba = lane;
      TEX_FMT_RGB565:   rgba = {tex_rep5(lane[15:11]), tex_rep6(lane[10:5]),
                                tex_rep5(lane[4:0]), 8'hFF};
      TEX_FMT_L8:       rgba = {lane[7:0], lane[7:0], lane[7:0], 8'hFF};
      TEX_FMT_A8:       rgba = {24'hFF_FFFF, lane[7:0]};
      default:          rgba = lane;
    endcase
  end

endmodule

// File: rtl/tex_texel_unpack.sv
// tex_texel_unpack: selects the addressed texel out of a 128-bit colour line
// and expands it to RGBA8888 through a two-stage valid/ready pipeline.
// Stage 1 captures the raw lane and format, stage 2 holds the expanded texel.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of tex_texel_unpack_if (packet in, texel out)
//   stat_texels / stat_stalls  out 32 (only with TEX_UNPACK_STATS_EN defined):
//          output transfers and output stall cycles, wrapping, cleared on reset
// Build option: define TEX_UNPACK_STATS_EN to add the statistics counters.
// Note: pkt_ready is combinational from texel_ready so a full pipeline can
// accept and emit in the same cycle; the consumer must not loop back to it.
module tex_texel_unpack
  import tex_texel_unpack_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  tex_texel_unpack_if.slave  bus
`ifdef TEX_UNPACK_STATS_EN
  ,
  output logic [31:0]        stat_texels,
  output logic [31:0]        stat_stalls
`endif
);

  logic                   adv1_s;
  logic                   adv2_s;
  logic [TEX_TEXEL_W-1:0] lane_s;
  logic [TEX_TEXEL_W-1:0] rgba_s;

  logic                   s1_valid_d, s1_valid_q;
  logic [TEX_TEXEL_W-1:0] s1_lane_d,  s1_lane_q;
  logic [1:0]             s1_fmt_d,   s1_fmt_q;
  logic                   s2_valid_d, s2_valid_q;
  logic [TEX_TEXEL_W-1:0] s2_rgba_d,  s2_rgba_q;

  // Lane selection; the start bit is the texel index times the texel width,
  // built by concatenating zeros below the relevant x_lsb bits.
  always_comb begin
    lane_s = '0;
    case (bus.tex_fmt)
      TEX_FMT_RGBA8888: lane_s = bus.color_pkt[{bus.x_lsb[1:0], 5'b0_0000} +: 32];
      TEX_FMT_RGB565:   lane_s = {16'h0000, bus.color_pkt[{bus.x_lsb[2:0], 4'b0000} +: 16]};
      TEX_FMT_L8:       lane_s = {24'h00_0000, bus.color_pkt[{bus.x_lsb, 3'b000} +: 8]};
      TEX_FMT_A8:       lane_s = {24'h00_0000, bus.color_pkt[{bus.x_lsb, 3'b000} +: 8]};
      default:          lane_s = '0;
    endcase
  end

  tex_fmt_expand u_expand (
    .lane (s1_lane_q),
    .fmt  (s1_fmt_q),
    .rgba (rgba_s)
  );

  // Stage advance and next-state for both pipeline stages
  always_comb begin
    adv2_s     = !s2_valid_q || bus.texel_ready;
    adv1_s     = !s1_valid_q || adv2_s;
    s1_valid_d = s1_valid_q;
    s1_lane_d  = s1_lane_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    s2_rgba_d  = s2_rgba_q;
    if (adv1_s) begin
      // Data registers load even when pkt_valid is low; the valid bit qualifies them.
      s1_valid_d = bus.pkt_valid;
      s1_lane_d  = lane_s;
      s1_fmt_d   = bus.tex_fmt;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (adv2_s) begin
      s2_valid_d = s1_valid_q;
      s2_rgba_d  = rgba_s;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_lane_q  <= '0;
      s1_fmt_q   <= TEX_FMT_RGBA8888;
      s2_valid_q <= 1'b0;
      s2_rgba_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lane_q  <= s1_lane_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      s2_rgba_q  <= s2_rgba_d;
    end
  end

  assign bus.pkt_ready   = adv1_s;
  assign bus.texel_valid = s2_valid_q;
  assign bus.texel_rgba  = s2_rgba_q;

`ifdef TEX_UNPACK_STATS_EN
  logic [31:0] stat_texels_d, stat_texels_q;
  logic [31:0] stat_stalls_d, stat_stalls_q;

  // Statistics next-state: count output transfers and output stall cycles
  always_comb begin
    stat_texels_d = stat_texels_q;
    stat_stalls_d = stat_stalls_q;
    if (s2_valid_q && bus.texel_ready) begin
      stat_texels_d = stat_texels_q + 32'd1;
    end else begin
      stat_texels_d = stat_texels_q;
    end
    if (s2_valid_q && !bus.texel_ready) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end else begin
      stat_stalls_d = stat_stalls_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_texels_q <= 32'd0;
      stat_stalls_q <= 32'd0;
    end else begin
      stat_texels_q <= stat_texels_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_texels = stat_texels_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_tex_texel_unpack.sv
// Self-checking bench for tex_texel_unpack.
// Stimulus tasks drive packets; one monitor process (on the falling edge)
// pushes the reference texel of every accepted packet into a queue, pops and
// compares on every output transfer, and checks pkt_ready against the
// occupancy implied by the queue. Define TEX_UNPACK_STATS_EN to also check
// the statistics counters.
module tb_tex_texel_unpack;
  import tex_texel_unpack_pkg::*;

  logic clk;
  logic reset;
  tex_texel_unpack_if bus ();

`ifdef TEX_UNPACK_STATS_EN
  logic [31:0] stat_texels;
  logic [31:0] stat_stalls;
`endif

  tex_texel_unpack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef TEX_UNPACK_STATS_EN
    ,
    .stat_texels (stat_texels),
    .stat_stalls (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;          // 0 always ready, 1 pattern 1,0,0, 2 random, 3 never
  logic [31:0] exp_q[$];
  bit after_rst = 1'b1;
`ifdef TEX_UNPACK_STATS_EN
  logic [31:0] m_texels = 32'd0;
  logic [31:0] m_stalls = 32'd0;
`endif

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: texel selection and RGBA8888 expansion from plain arithmetic.
  function automatic logic [31:0] ref_texel(input logic [127:0] p, input int x, input int f);
    logic [127:0] sh;
    logic [31:0] h, r, g, b, v;
    case (f)
      0: begin
        sh = p >> (32 * (x % 4));
        return sh[31:0];
      end
      1: begin
        sh = p >> (16 * (x % 8));
        h = {16'h0000, sh[15:0]};
        r = h / 2048; g = (h / 32) % 64; b = h % 32;
        r = r * 8 + r / 4; g = g * 4 + g / 16; b = b * 8 + b / 4;
        return r * 32'h0100_0000 + g * 32'h0001_0000 + b * 32'h0000_0100 + 32'd255;
      end
      2: begin
        sh = p >> (8 * x);
        v = {24'h0, sh[7:0]};
        return v * 32'h0101_0100 + 32'd255;
      end
      default: begin
        sh = p >> (8 * x);
        return 32'hFFFF_FF00 + {24'h0, sh[7:0]};
      end
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        after_rst = 1'b1;
`ifdef TEX_UNPACK_STATS_EN
        m_texels = 32'd0;
        m_stalls = 32'd0;
`endif
      end else begin
        if (after_rst) begin
          check(bus.texel_valid == 1'b0, "rst_texel_valid", {31'd0, bus.texel_valid}, 32'd0);
          check(bus.texel_rgba == 32'd0, "rst_texel_rgba", bus.texel_rgba, 32'd0);
          check(bus.pkt_ready == 1'b1, "rst_pkt_ready", {31'd0, bus.pkt_ready}, 32'd1);
          after_rst = 1'b0;
        end
        check(bus.pkt_ready == (exp_q.size() < 2 || bus.texel_ready), "pkt_ready",
              {31'd0, bus.pkt_ready}, {31'd0, (exp_q.size() < 2 || bus.texel_ready)});
`ifdef TEX_UNPACK_STATS_EN
        check(stat_texels == m_texels, "stat_texels", stat_texels, m_texels);
        check(stat_stalls == m_stalls, "stat_stalls", stat_stalls, m_stalls);
        if (bus.texel_valid && bus.texel_ready) m_texels = m_texels + 32'd1;
        if (bus.texel_valid && !bus.texel_ready) m_stalls = m_stalls + 32'd1;
`endif
        if (bus.texel_valid && bus.texel_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_texel", bus.texel_rgba, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check(bus.texel_rgba == e, "texel", bus.texel_rgba, e);
          end
        end
        if (bus.pkt_valid && bus.pkt_ready)
          exp_q.push_back(ref_texel(bus.color_pkt, int'(bus.x_lsb), int'(bus.tex_fmt)));
      end
    end
  end

  // Consumer ready generator
  initial begin
    int cyc = 0;
    bus.texel_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0:       bus.texel_ready = 1'b1;
        1:       bus.texel_ready = (cyc % 3 == 0);
        2:       bus.texel_ready = ($urandom_range(0, 3) != 0);
        default: bus.texel_ready = 1'b0;
      endcase
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer one packet and hold it until accepted (bounded).
  task automatic send(input logic [127:0] p, input logic [3:0] x, input logic [1:0] f);
    bit done = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.color_pkt = p;
    bus.x_lsb     = x;
    bus.tex_fmt   = f;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      done = bus.pkt_ready;
      @(posedge clk); #1;
    end
    if (!done) check(1'b0, "accept_timeout", 32'd0, 32'd1);
    bus.pkt_valid = 1'b0;
  endtask

  // Single packet on an empty, unstalled pipe: check latency and exact value.
  task automatic directed(input logic [127:0] p, input logic [3:0] x, input logic [1:0] f,
                          input logic [31:0] exp, input string nm);
    int n = 0;
    send(p, x, f);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.texel_valid && n < 10);
    check(n == 2, {nm, "_latency"}, n, 32'd2);
    check(bus.texel_rgba == exp, nm, bus.texel_rgba, exp);
    idle(3);
  endtask

  function automatic logic [127:0] rnd_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(exp_q.size() == 0, "drain", exp_q.size(), 32'd0);
    idle(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus
  initial begin
    logic [127:0] p;
    reset = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.color_pkt = '0;
    bus.x_lsb = 4'd0;
    bus.tex_fmt = 2'd0;
    idle(3);
    reset = 1'b0;
    rdy_mode = 0;
    idle(3);

    // Directed format cases
    directed(128'h44444444_33333333_22222222_11111111, 4'd2, TEX_FMT_RGBA8888, 32'h3333_3333, "rgba_x2");
    p = rnd_pkt(); p[80 +: 16] = 16'hF81F;
    directed(p, 4'd5, TEX_FMT_RGB565, 32'hFF00_FFFF, "rgb565_f81f");
    p = rnd_pkt(); p[80 +: 16] = 16'h0000;
    directed(p, 4'd5, TEX_FMT_RGB565, 32'h0000_00FF, "rgb565_zero");
    p = rnd_pkt(); p[120 +: 8] = 8'h80;
    directed(p, 4'd15, TEX_FMT_L8, 32'h8080_80FF, "l8_x15");
    p = rnd_pkt(); p[0 +: 8] = 8'h3C;
    directed(p, 4'd0, TEX_FMT_A8, 32'hFFFF_FF3C, "a8_x0");

    // Streaming 8 packets with ready pattern 1,0,0
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(rnd_pkt(), 4'($urandom), 2'($urandom));
    drain();

    // Random stress with random gaps and random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send(rnd_pkt(), 4'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Reset with two texels buffered: both must be discarded
    rdy_mode = 3;
    idle(1);
    send(rnd_pkt(), 4'($urandom), 2'($urandom));
    send(rnd_pkt(), 4'($urandom), 2'($urandom));
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    rdy_mode = 0;
    idle(10);

    // Short post-reset burst to confirm normal operation resumes
    for (int i = 0; i < 10; i++)
      send(rnd_pkt(), 4'($urandom), 2'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
